// File: rtl/fcs_frame_sequencer_if.sv
// Bundle between the frame sequencer, the packet builder, the frame RAM,
// the external CRC32 engine and the TX MAC.
interface fcs_frame_sequencer_if #(
    parameter int ADDR_W = 11
);
    logic              start;
    logic [ADDR_W-1:0] frame_len;
    logic              busy;
    logic              len_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              crc_init;
    logic              crc_en;
    logic [7:0]        crc_byte;
    logic [31:0]       crc_value;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_byte;
    logic              out_last;
    logic              done;

    // Sequencer side.
    modport slave (
        input  start, frame_len, ram_data, crc_value, out_ready,
        output busy, len_err, ram_addr, crc_init, crc_en, crc_byte,
               out_valid, out_byte, out_last, done
    );

    // Environment side: packet builder, RAM, CRC engine and MAC.
    modport master (
        output start, frame_len, ram_data, crc_value, out_ready,
        input  busy, len_err, ram_addr, crc_init, crc_en, crc_byte,
               out_valid, out_byte, out_last, done
    );
endinterface

// File: rtl/fcs_frame_sequencer.sv
// Streams one frame from the frame RAM to the MAC, feeding the external CRC32
// engine in lockstep, then appends the four FCS bytes LSB first.
module fcs_frame_sequencer #(
    parameter int ADDR_W  = 11,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int CRC_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    fcs_frame_sequencer_if.slave bus,
    output logic [2:0]           dbg_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DATA  = 3'd2,
        CWAIT = 3'd3,
        FCS   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [ADDR_W-1:0] len, len_nxt;
    logic [31:0]       fcs_reg, fcs_nxt;
    logic              len_err_q, len_err_nxt;
    logic              done_q, done_nxt;
    logic              len_ok;
    logic              acc;

    // Handshake: a byte moves to the MAC in any cycle with out_valid & out_ready;
    // while out_valid & !out_ready, out_byte and out_last stay unchanged.
    assign bus.out_valid = (state == DATA) || (state == FCS);
    assign acc           = bus.out_valid && bus.out_ready;
    assign bus.crc_en    = acc && (state == DATA);
    assign bus.crc_byte  = bus.out_byte;
    assign bus.busy      = (state != IDLE);
    assign bus.len_err   = len_err_q;
    assign bus.done      = done_q;
    assign dbg_state     = state;

    assign len_ok = (bus.frame_len >= ADDR_W'(MIN_LEN)) &&
                    (bus.frame_len <= ADDR_W'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            len       <= '0;
            fcs_reg   <= '0;
            len_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            len       <= len_nxt;
            fcs_reg   <= fcs_nxt;
            len_err_q <= len_err_nxt;
            done_q    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        len_nxt      = len;
        fcs_nxt      = fcs_reg;
        len_err_nxt  = 1'b0;
        done_nxt     = 1'b0;
        bus.ram_addr = '0;
        bus.crc_init = 1'b0;
        bus.out_byte = '0;
        bus.out_last = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (len_ok) begin
                        state_nxt = LOAD;
                        len_nxt   = bus.frame_len;
                        idx_nxt   = '0;
                    end else begin
                        len_err_nxt = 1'b1;
                    end
                end
            end
            LOAD: begin
                bus.crc_init = 1'b1;
                state_nxt    = DATA;
            end
            DATA: begin
                bus.out_byte = bus.ram_data;
                // Prefetch the next address only on acceptance so ram_data tracks idx.
                bus.ram_addr = idx + ADDR_W'(acc);
                if (acc) begin
                    if (idx == len - ADDR_W'(1)) begin
                        state_nxt = CWAIT;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + ADDR_W'(1);
                    end
                end
            end
            CWAIT: begin
                // idx doubles as the CRC settle counter here.
                if (idx == ADDR_W'(CRC_LAT - 1)) begin
                    fcs_nxt   = bus.crc_value;
                    idx_nxt   = '0;
                    state_nxt = FCS;
                end else begin
                    idx_nxt = idx + ADDR_W'(1);
                end
            end
            FCS: begin
                case (idx[1:0])
                    2'd0:    bus.out_byte = fcs_reg[7:0];
                    2'd1:    bus.out_byte = fcs_reg[15:8];
                    2'd2:    bus.out_byte = fcs_reg[23:16];
                    default: bus.out_byte = fcs_reg[31:24];
                endcase
                bus.out_last = (idx[1:0] == 2'd3);
                if (acc) begin
                    if (idx[1:0] == 2'd3) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + ADDR_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
